add8_accum: RTL and testbench



---
 rtl/add8_accum.sv | 113 +++++++++++
 tb/tb_add8_accum.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_accum.sv
// Frame accumulator behind the 8-bit adder: sums COUNT accepted samples and
// hands each frame total downstream on a valid/ready port with an overflow flag.
module add8_accum #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4,
    parameter int SATURATE  = 0
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic [WIDTH-1:0]     I,
    input  logic                 I_valid,
    output logic                 I_ready,
    input  logic                 CLR,
    output logic [ACC_WIDTH-1:0] O,
    output logic                 O_valid,
    input  logic                 O_ready,
    output logic                 O_ovf
);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t               state;
    state_t               state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [7:0]           cnt;
    logic                 ovf;
    logic                 accept;
    logic                 emit;
    logic                 last;
    logic [ACC_WIDTH:0]   add_res;

    // Returns {carry, value}; with saturation the value pins at all-ones and
    // stays there because any further non-zero add carries again.
    function automatic logic [ACC_WIDTH:0] add_sat(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0]     b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, b};
        if ((SATURATE != 0) && s[ACC_WIDTH]) begin
            return {1'b1, {ACC_WIDTH{1'b1}}};
        end
        return s;
    endfunction

    assign accept  = I_valid & I_ready;
    assign emit    = O_valid & O_ready;
    assign last    = (cnt == 8'(COUNT - 1));
    assign add_res = add_sat(acc, I);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (CLR) begin
            state_next = ACCUM;
        end else if (accept && last) begin
            state_next = EMIT;
        end else if (emit) begin
            state_next = ACCUM;
        end
    end

    // In EMIT the upstream may only move when the held result is leaving.
    always_comb begin
        I_ready = 1'b1;
        if (state == EMIT) begin
            I_ready = O_ready;
        end
    end

    // acc/cnt/ovf are zero whenever a result is held, so an accept in EMIT
    // naturally starts the next frame from a clean accumulator.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            O       <= '0;
            O_valid <= 1'b0;
            O_ovf   <= 1'b0;
        end else if (CLR) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            O_valid <= 1'b0;
        end else begin
            if (emit) begin
                O_valid <= 1'b0;
            end
            if (accept) begin
                if (last) begin
                    O       <= add_res[ACC_WIDTH-1:0];
                    O_ovf   <= ovf | add_res[ACC_WIDTH];
                    O_valid <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                end else begin
                    acc <= add_res[ACC_WIDTH-1:0];
                    cnt <= cnt + 8'd1;
                    ovf <= ovf | add_res[ACC_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_add8_accum.sv
// Bench for add8_accum: four configurations (base, 9-bit wrap, 9-bit saturate,
// COUNT=1) driven with directed frames; results checked through per-instance queues.
module tb_add8_accum;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din  [4];
    logic        vin  [4];
    logic        clr  [4];
    logic        ordy [4];
    logic        rdy  [4];
    logic        ov   [4];
    logic        ovf  [4];
    logic [15:0] dout [4];
    logic [15:0] o_base;
    logic [15:0] o_one;
    logic [8:0]  o_wrap;
    logic [8:0]  o_sat;

    logic [16:0] exp_q [4][$];
    int checks;
    int failures;

    assign dout[0] = o_base;
    assign dout[1] = {7'b0, o_wrap};
    assign dout[2] = {7'b0, o_sat};
    assign dout[3] = o_one;

    add8_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4), .SATURATE(0)) u_base (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(din[0]), .I_valid(vin[0]), .I_ready(rdy[0]),
        .CLR(clr[0]), .O(o_base), .O_valid(ov[0]), .O_ready(ordy[0]), .O_ovf(ovf[0]));

    add8_accum #(.WIDTH(8), .ACC_WIDTH(9), .COUNT(4), .SATURATE(0)) u_wrap (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(din[1]), .I_valid(vin[1]), .I_ready(rdy[1]),
        .CLR(clr[1]), .O(o_wrap), .O_valid(ov[1]), .O_ready(ordy[1]), .O_ovf(ovf[1]));

    add8_accum #(.WIDTH(8), .ACC_WIDTH(9), .COUNT(4), .SATURATE(1)) u_sat (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(din[2]), .I_valid(vin[2]), .I_ready(rdy[2]),
        .CLR(clr[2]), .O(o_sat), .O_valid(ov[2]), .O_ready(ordy[2]), .O_ovf(ovf[2]));

    add8_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(1), .SATURATE(0)) u_one (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(din[3]), .I_valid(vin[3]), .I_ready(rdy[3]),
        .CLR(clr[3]), .O(o_one), .O_valid(ov[3]), .O_ready(ordy[3]), .O_ovf(ovf[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One valid sample presented for one clock edge.
    task automatic feed(input int k, input logic [7:0] d);
        din[k] = d;
        vin[k] = 1'b1;
        @(posedge clk);
        #1;
        vin[k] = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            din[k]  = 8'h00;
            vin[k]  = 1'b0;
            clr[k]  = 1'b0;
            ordy[k] = 1'b1;
        end

        fork
            begin
                repeat (5000) @(posedge clk);
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    if (rst_n && ov[k] && ordy[k]) begin
                        if (exp_q[k].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_out inst=%0d actual=0x%0h required=none",
                                     k, {ovf[k], dout[k]});
                        end else begin
                            chk($sformatf("out_inst%0d", k), {15'b0, ovf[k], dout[k]},
                                {15'b0, exp_q[k].pop_front()});
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_o_valid", {31'b0, ov[0]}, 32'd0);
        chk("rst_o", {16'b0, dout[0]}, 32'd0);
        chk("rst_o_ovf", {31'b0, ovf[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_i_ready", {31'b0, rdy[0]}, 32'd1);

        // Basic frame: 0x10+0x20+0x30+0x40
        exp_q[0].push_back({1'b0, 16'h00A0});
        feed(0, 8'h10);
        feed(0, 8'h20);
        feed(0, 8'h30);
        feed(0, 8'h40);
        chk("basic_latency_valid", {31'b0, ov[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("basic_pulse_drop", {31'b0, ov[0]}, 32'd0);

        // Back-pressure
        ordy[0] = 1'b0;
        exp_q[0].push_back({1'b0, 16'h000A});
        exp_q[0].push_back({1'b0, 16'h0004});
        feed(0, 8'h01);
        feed(0, 8'h02);
        feed(0, 8'h03);
        feed(0, 8'h04);
        din[0] = 8'h01;
        vin[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_i_ready_low", {31'b0, rdy[0]}, 32'd0);
            chk("bp_o_valid_held", {31'b0, ov[0]}, 32'd1);
            chk("bp_o_stable", {16'b0, dout[0]}, 32'h000A);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        #1;
        chk("bp_i_ready_pass", {31'b0, rdy[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_emit_accept_drop", {31'b0, ov[0]}, 32'd0);
        feed(0, 8'h01);
        feed(0, 8'h01);
        feed(0, 8'h01);
        chk("bp_new_frame_valid", {31'b0, ov[0]}, 32'd1);
        @(posedge clk);
        #1;

        // Overflow: wrap and saturate side by side, 4 x 0xFF into 9 bits
        exp_q[1].push_back({1'b1, 16'h01FC});
        exp_q[2].push_back({1'b1, 16'h01FF});
        din[1] = 8'hFF;
        din[2] = 8'hFF;
        vin[1] = 1'b1;
        vin[2] = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        vin[1] = 1'b0;
        vin[2] = 1'b0;
        chk("wrap_valid", {31'b0, ov[1]}, 32'd1);
        chk("sat_valid", {31'b0, ov[2]}, 32'd1);
        @(posedge clk);
        #1;

        // COUNT=1 streaming
        exp_q[3].push_back({1'b0, 16'h0005});
        exp_q[3].push_back({1'b0, 16'h0006});
        exp_q[3].push_back({1'b0, 16'h0007});
        din[3] = 8'h05;
        vin[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("one_valid_0", {31'b0, ov[3]}, 32'd1);
        chk("one_ready_0", {31'b0, rdy[3]}, 32'd1);
        din[3] = 8'h06;
        @(posedge clk);
        #1;
        chk("one_valid_1", {31'b0, ov[3]}, 32'd1);
        chk("one_ready_1", {31'b0, rdy[3]}, 32'd1);
        din[3] = 8'h07;
        @(posedge clk);
        #1;
        chk("one_valid_2", {31'b0, ov[3]}, 32'd1);
        chk("one_ready_2", {31'b0, rdy[3]}, 32'd1);
        vin[3] = 1'b0;
        @(posedge clk);
        #1;
        chk("one_drain", {31'b0, ov[3]}, 32'd0);

        // CLR mid-frame, with a sample offered in the clearing cycle
        exp_q[0].push_back({1'b0, 16'h0004});
        feed(0, 8'h11);
        feed(0, 8'h22);
        din[0] = 8'h33;
        vin[0] = 1'b1;
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        vin[0] = 1'b0;
        clr[0] = 1'b0;
        chk("clr_no_output", {31'b0, ov[0]}, 32'd0);
        repeat (4) feed(0, 8'h01);
        @(posedge clk);
        #1;

        // Asynchronous reset while a result is held
        ordy[0] = 1'b0;
        repeat (4) feed(0, 8'h02);
        chk("ar_held_valid", {31'b0, ov[0]}, 32'd1);
        chk("ar_held_o", {16'b0, dout[0]}, 32'h0008);
        rst_n = 1'b0;
        #1;
        chk("ar_o_valid_now", {31'b0, ov[0]}, 32'd0);
        chk("ar_o_now", {16'b0, dout[0]}, 32'd0);
        chk("ar_i_ready", {31'b0, rdy[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        exp_q[0].push_back({1'b0, 16'h000C});
        repeat (4) feed(0, 8'h03);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("queue_empty_inst%0d", k), exp_q[k].size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
